mdr_mem_interface: RTL and testbench

Memory data/address interface stage for the 32-bit datapath. Holds the MAR and MDR, captures values from the shared 32-bit bus, and runs a request/ready handshake with word-addressed memory for reads and writes. MDR contents drive the bus multiplexer's MDR source input, so this block is both a consumer of the bus and a bus source. The control unit sequences it through load strobes and observes `busy`/`done`.

---
 rtl/mdr_mem_interface.sv | 165 ++++++++++++++++
 tb/tb_mdr_mem_interface.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// mdr_mem_interface
//
// Memory data/address stage of the 32-bit datapath. Holds MAR and MDR,
// captures them from the shared bus, and runs a request/ready handshake
// with word-addressed memory for reads and writes. MDR contents are also
// driven back towards the bus multiplexer on MDRout.
//
// Handshake: mem_rd / mem_wr is raised the cycle after the request is
// sampled and held, with mem_addr / mem_wdata stable, until mem_ready is
// sampled high; the transfer completes on that edge and done pulses for
// exactly one cycle afterwards. mem_ready outside a transaction is ignored.
//
// Optional feature: define MDR_MEM_TIMEOUT_EN to bound each wait at
// TIMEOUT cycles; on expiry the request is dropped, done pulses and the
// sticky err flag is set. Without the macro err is tied to 0.
//
// Ports:
//   clk        in   sole clock, rising edge
//   clr        in   synchronous active-low reset
//   BusMuxOut  in   shared 32-bit bus value
//   MARin      in   load MAR from bus (IDLE only)
//   MDRin      in   load MDR; with Read=1 starts a memory read instead
//   Read       in   selects memory read as MDR source
//   Write      in   start a memory write of the current MDR
//   mem_addr   out  current MAR
//   mem_wdata  out  current MDR
//   mem_rd     out  read request, held until mem_ready
//   mem_wr     out  write request, held until mem_ready
//   mem_rdata  in   read data, valid with mem_ready during a read
//   mem_ready  in   memory completion
//   MDRout     out  MDR contents for the bus multiplexer
//   busy       out  1 while waiting on memory
//   done       out  one-cycle completion pulse
//   err        out  sticky timeout flag
//   dbg_state  out  current FSM state (0 IDLE, 1 RD_WAIT, 2 WR_WAIT)
// ---------------------------------------------------------------------------
module mdr_mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       MDRout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       mdr;

`ifdef MDR_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign MDRout    = mdr;
    assign dbg_state = state;

`ifndef MDR_MEM_TIMEOUT_EN
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= IDLE;
            mar    <= '0;
            mdr    <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MDR_MEM_TIMEOUT_EN
            wait_cnt <= '0;
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // MAR load lands on the same edge the request is taken,
                    // so a combined MARin+request uses the new address.
                    if (MARin)
                        mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin && !Read)
                        mdr <= BusMuxOut;
                    // Read wins over Write when both are requested.
                    if (MDRin && Read) begin
                        state  <= RD_WAIT;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
`ifdef MDR_MEM_TIMEOUT_EN
                        wait_cnt <= '0;
                        err      <= 1'b0;
`endif
                    end else if (Write) begin
                        state  <= WR_WAIT;
                        mem_wr <= 1'b1;
                        busy   <= 1'b1;
`ifdef MDR_MEM_TIMEOUT_EN
                        wait_cnt <= '0;
                        err      <= 1'b0;
`endif
                    end
                end

                RD_WAIT, WR_WAIT: begin
                    if (mem_ready) begin
                        if (state == RD_WAIT)
                            mdr <= mem_rdata;
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef MDR_MEM_TIMEOUT_EN
                    // wait_cnt counts completed wait cycles; the TIMEOUT-th
                    // one without mem_ready abandons the transfer.
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mdr_mem_interface
//
// Directed steps followed by a randomized run. The reference model is a
// plain memory array plus the expected MAR/MDR/err values; read data
// expected at completion is queued in exp_q when the request is issued.
// Inputs are driven 1 ns after the rising edge and outputs sampled there.
// ---------------------------------------------------------------------------
module tb_mdr_mem_interface;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    // clock / reset
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic [31:0]       BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [31:0]       MDRout;
    logic              busy, done, err;
    logic [1:0]        dbg_state;

    mdr_mem_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .MDRout(MDRout), .busy(busy), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // reference model / scoreboard
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] exp_mar;
    logic [31:0]       exp_mdr;
    logic              exp_err;
    logic [31:0]       exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_addr"},  32'(mem_addr), 32'(exp_mar));
        chk({tag, "_mdr"},   MDRout, exp_mdr);
        chk({tag, "_wdata"}, mem_wdata, exp_mdr);
        chk({tag, "_rd"},    32'(mem_rd), 0);
        chk({tag, "_wr"},    32'(mem_wr), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_err"},   32'(err), 32'(exp_err));
    endtask

    // driver tasks
    task automatic bus_mar(input logic [31:0] v);
        MARin = 1'b1; BusMuxOut = v;
        tick(); idle_inputs();
        exp_mar = v[ADDR_W-1:0];
        chk("bus_mar", 32'(mem_addr), 32'(exp_mar));
    endtask

    task automatic bus_mdr(input logic [31:0] v);
        MDRin = 1'b1; Read = 1'b0; BusMuxOut = v;
        tick(); idle_inputs();
        exp_mdr = v;
        chk("bus_mdr", MDRout, exp_mdr);
        chk("bus_mdr_done", 32'(done), 0);
        chk("bus_mdr_busy", 32'(busy), 0);
    endtask

    task automatic do_read(input int waits, input logic junk,
                           input logic with_mar, input logic [31:0] mar_v);
        logic [31:0] data;
        MDRin = 1'b1; Read = 1'b1;
        Write = 1'($urandom_range(0, 1));
        if (with_mar) begin
            MARin = 1'b1; BusMuxOut = mar_v;
            exp_mar = mar_v[ADDR_W-1:0];
        end
        tick(); idle_inputs();
        data = mem[exp_mar];
        exp_q.push_back(data);
        exp_err = 1'b0;
        chk("rd_req",  32'(mem_rd), 1);
        chk("rd_nowr", 32'(mem_wr), 0);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_addr", 32'(mem_addr), 32'(exp_mar));
        chk("rd_err",  32'(err), 0);
        for (int i = 0; i < waits; i++) begin
            if (junk) begin
                MARin = 1'b1; MDRin = 1'b1; Write = 1'b1;
                Read = 1'($urandom_range(0, 1));
                BusMuxOut = (i == 0) ? 32'h1FF : $urandom;
            end
            mem_rdata = $urandom;
            tick(); idle_inputs();
            chk("rd_wait_rd",   32'(mem_rd), 1);
            chk("rd_wait_addr", 32'(mem_addr), 32'(exp_mar));
            chk("rd_wait_mdr",  MDRout, exp_mdr);
            chk("rd_wait_done", 32'(done), 0);
        end
        mem_ready = 1'b1; mem_rdata = data;
        tick(); idle_inputs();
        exp_mdr = exp_q.pop_front();
        chk("rd_done",   32'(done), 1);
        chk("rd_mdr",    MDRout, exp_mdr);
        chk("rd_drop",   32'(mem_rd), 0);
        chk("rd_idle",   32'(busy), 0);
    endtask

    task automatic do_write(input int waits);
        Write = 1'b1;
        tick(); idle_inputs();
        exp_err = 1'b0;
        chk("wr_req",   32'(mem_wr), 1);
        chk("wr_nord",  32'(mem_rd), 0);
        chk("wr_busy",  32'(busy), 1);
        chk("wr_data",  mem_wdata, exp_mdr);
        chk("wr_addr",  32'(mem_addr), 32'(exp_mar));
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wr_wait_wr",   32'(mem_wr), 1);
            chk("wr_wait_data", mem_wdata, exp_mdr);
            chk("wr_wait_done", 32'(done), 0);
        end
        mem_ready = 1'b1;
        tick(); idle_inputs();
        mem[exp_mar] = exp_mdr;
        chk("wr_done", 32'(done), 1);
        chk("wr_drop", 32'(mem_wr), 0);
        chk("wr_idle", 32'(busy), 0);
        chk("wr_mdr",  MDRout, exp_mdr);
    endtask

    initial begin
        clr = 1'b0; BusMuxOut = '0; mem_rdata = '0;
        idle_inputs();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        exp_mar = '0; exp_mdr = '0; exp_err = 1'b0;

        // reset, then bus load
        tick(); tick();
        clr = 1'b1;
        chk_quiet("reset");
        chk("reset_done", 32'(done), 0);
        bus_mdr(32'hDEADBEEF);

        // zero-wait read
        bus_mar(32'h0000_0042);
        mem[9'h042] = 32'h12345678;
        do_read(0, 1'b0, 1'b0, 32'h0);
        chk("zw_read_val", MDRout, 32'h12345678);

        // write with 3 wait cycles
        bus_mdr(32'hA5A5A5A5);
        do_write(3);

        // commands ignored while busy
        do_read(3, 1'b1, 1'b0, 32'h0);
        tick();
        chk_quiet("after_busy");

        // MARin together with a read request
        do_read(1, 1'b0, 1'b1, 32'h0000_0123);

        // reset mid-read
        MDRin = 1'b1; Read = 1'b1;
        tick(); idle_inputs();
        chk("mr_req", 32'(mem_rd), 1);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        exp_mar = '0; exp_mdr = '0; exp_err = 1'b0;
        chk_quiet("mid_reset");
        mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick(); idle_inputs();
        chk("late_ready_done", 32'(done), 0);
        chk_quiet("late_ready");

`ifdef MDR_MEM_TIMEOUT_EN
        // timeout: no ready for TIMEOUT wait cycles
        bus_mar(32'h0000_0077);
        MDRin = 1'b1; Read = 1'b1;
        tick(); idle_inputs();
        chk("to_busy0", 32'(busy), 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            chk("to_busy", 32'(busy), 1);
            chk("to_nodone", 32'(done), 0);
        end
        tick();
        exp_err = 1'b1;
        chk("to_done", 32'(done), 1);
        chk_quiet("timeout");
        do_read(0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("to_err_clear", 32'(err), 0);
`else
        // without the timeout a long wait simply keeps waiting
        do_read(20, 1'b0, 1'b0, 32'h0);
        chk("no_to_err", 32'(err), 0);
`endif

        // randomized run against the memory model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: bus_mar($urandom);
                1: bus_mdr($urandom);
                2: do_read(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), $urandom);
                3: do_write(int'($urandom_range(0, 4)));
                default: begin
                    mem_ready = 1'b1; mem_rdata = $urandom;
                    tick(); idle_inputs();
                    chk("idle_ready_done", 32'(done), 0);
                    chk_quiet("idle_ready");
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
